seg7_scan: RTL and testbench
============================

Name: seg7_scan

Overview:
- Parametrised, time-multiplexed driver for an NDIG-digit common-anode 7-segment display.
- Latches a packed hex word, decimal points and per-digit blank mask into a shadow register on a load strobe.
- Scans the digits one at a time, with an anti-ghosting blank interval and optional leading-zero suppression.
- Sits between the debug/IO register block and the board display pins.

Parameters:
- NDIG, 8, number of digits (1..16).
- SCAN_DIV, 1000, clock cycles each digit is selected (>= BLANK_CYC+2).
- BLANK_CYC, 4, cycles at the start of each digit slot with all anodes off (0 disables).
- AN_ACT_LOW, 1, 1 = anode enables active-low, 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- load  in  1  1-cycle strobe; captures data/dp/blank into the shadow register.
- data  in  4*NDIG  digit nibbles; digit i = data[4i+3:4i]; digit 0 is rightmost.
- dp  in  NDIG  decimal point request per digit (1 = lit).
- blank  in  NDIG  force digit off (1 = off).
- lz_en  in  1  leading-zero suppression enable (level, not shadowed).
- nhex  out  7  segments gfedcba, 0 = lit, registered.
- ndp  out  1  decimal point, 0 = lit, registered.
- an  out  NDIG  digit enables, polarity per AN_ACT_LOW, registered.
- dig_idx  out  $clog2(NDIG) (min 1)  digit currently scanned, registered.

Behaviour:
Clock and reset:
- One clock domain: clk.
- Reset is synchronous and active-low on rst_n.
- Reset state: shadow regs 0, scan_cnt 0, dig_idx 0, nhex 7'h7F, ndp 1, an all inactive.

Shadow load:
- load=1 at edge N copies data/dp/blank into the shadow at N.
- New values appear on the outputs no earlier than edge N+1.
- load held high reloads every cycle; no other side effect.

Scan timing:
- scan_cnt counts 0..SCAN_DIV-1.
- At terminal count, scan_cnt wraps to 0 and dig_idx advances by 1, wrapping NDIG-1 -> 0.
- Each digit is selected for exactly SCAN_DIV cycles; full frame = NDIG*SCAN_DIV cycles.

Output registers (updated every edge from the next-state scan_cnt/dig_idx):
- If next scan_cnt < BLANK_CYC: an all inactive, nhex 7'h7F, ndp 1.
- Otherwise: an has only bit dig_idx active.
- Digit off condition: blank[dig_idx]=1, or the digit is suppressed. The digit then drives nhex 7'h7F and ndp 1, but its anode is still asserted.
- Otherwise nhex = decode(nibble). Decode table, hex: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:58 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Otherwise ndp = ~dp[dig_idx].

Leading-zero suppression (lz_en=1):
- Digit i is suppressed iff i>0 and every shadow nibble at positions i..NDIG-1 is 0.
- Digit 0 is never suppressed; all-zero data shows "0".
- A dp bit set on a suppressed digit does not override suppression.
- Suppression is combinational on the shadow and evaluated every cycle.

Boundary cases:
- NDIG=1: dig_idx stays 0 and an is constant-active outside the blank interval.
- BLANK_CYC=0: an is never blanked.
- Reset mid-frame restarts at digit 0, scan_cnt 0, with outputs blanked on the first cycle after release.
- load coincident with a digit change: the new digit uses the new shadow from the edge after load.

Test Plan:
- Reset: rst_n=0 for 3 cycles -> nhex=7F, ndp=1, an=FF (NDIG=8, AN_ACT_LOW=1), dig_idx=0; held through reset regardless of load.
- Decode sweep: NDIG=8, SCAN_DIV=8, BLANK_CYC=2, load data=32'hFEDCBA98 -> per slot, cycles 0-1 an=FF; cycles 2-7 an has the single 0 bit at dig_idx and nhex follows the table, e.g. digit0=00, digit7=0E; frame length = 64 cycles.
- Leading-zero: lz_en=1, data=32'h00000450 -> digits 7..3 show 7F with anode active, digit2=19, digit1=12, digit0=40; data=0 -> only digit0 shows 40.
- Blank/dp: blank=8'h02, dp=8'h05 -> digit1 nhex=7F/ndp=1; digits 0 and 2 ndp=0; others ndp=1.
- Load timing: load pulse with new data while digit3 is active mid-slot -> outputs change on the cycle after load; no glitch value between the old and new digit.
- Wrap/reset mid-frame: run 1.5 frames, assert rst_n=0 at dig_idx=5 -> next cycle dig_idx=0, an inactive; after release, digit0 is displayed after BLANK_CYC cycles.

Source files
------------

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for an NDIG-digit common-anode 7-segment display.
// Shadowed digit data, per-slot anti-ghost blanking, leading-zero suppression.
module seg7_scan #(
  parameter int NDIG       = 8,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 4,
  parameter int AN_ACT_LOW = 1,
  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [4*NDIG-1:0] data,
  input  logic [NDIG-1:0]   dp,
  input  logic [NDIG-1:0]   blank,
  input  logic              lz_en,
  output logic [6:0]        nhex,
  output logic              ndp,
  output logic [NDIG-1:0]   an,
  output logic [DW-1:0]     dig_idx
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST =
    DW'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_OFF =
    {NDIG{AN_ACT_LOW != 0}};

  logic [4*NDIG-1:0] data_q;
  logic [NDIG-1:0]   dp_q;
  logic [NDIG-1:0]   blank_q;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dig_q, dig_d;

  logic [6:0]      nhex_q, nhex_d;
  logic            ndp_q, ndp_d;
  logic [NDIG-1:0] an_q, an_d;

  logic [NDIG-1:0] supp;
  logic [NDIG-1:0] oh;
  logic [3:0]      nib;
  logic            sel_dp;
  logic            sel_off;
  logic            in_blank;

  function automatic logic [6:0] seg(
    input logic [3:0] v
  );
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h58;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '0;
    end else if (load) begin
      data_q  <= data;
      dp_q    <= dp;
      blank_q <= blank;
    end
  end

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    dig_d = dig_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (dig_q == DIG_LAST) begin
        dig_d = '0;
      end else begin
        dig_d = dig_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dig_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
    end
  end

  // Walk from the top digit down; a digit stays
  // suppressed while everything above it is zero.
  always_comb begin
    logic run;
    run  = 1'b1;
    supp = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      run = run & (data_q[4*i +: 4] == 4'h0);
      supp[i] = lz_en & run & (i != 0);
    end
  end

  always_comb begin
    nib     = '0;
    sel_dp  = 1'b0;
    sel_off = 1'b0;
    oh      = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (dig_d == DW'(i)) begin
        nib     = data_q[4*i +: 4];
        sel_dp  = dp_q[i];
        sel_off = blank_q[i] | supp[i];
        oh[i]   = 1'b1;
      end
    end
  end

  if (BLANK_CYC > 0) begin : g_blank
    assign in_blank = cnt_d < CW'(BLANK_CYC);
  end else begin : g_noblank
    assign in_blank = 1'b0;
  end

  // XOR with the idle pattern asserts the one
  // selected anode for either polarity.
  always_comb begin
    an_d   = AN_OFF;
    nhex_d = 7'h7F;
    ndp_d  = 1'b1;
    if (!in_blank) begin
      an_d = AN_OFF ^ oh;
      if (!sel_off) begin
        nhex_d = seg(nib);
        ndp_d  = ~sel_dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nhex_q <= 7'h7F;
      ndp_q  <= 1'b1;
      an_q   <= AN_OFF;
    end else begin
      nhex_q <= nhex_d;
      ndp_q  <= ndp_d;
      an_q   <= an_d;
    end
  end

  assign nhex    = nhex_q;
  assign ndp     = ndp_q;
  assign an      = an_q;
  assign dig_idx = dig_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: time-indexed display model checked every cycle
// on an 8-digit and a 1-digit instance, plus literal spot checks.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic        lz_en;
  logic [31:0] data;
  logic [7:0]  dp;
  logic [7:0]  blank;

  logic [6:0] nhex0;
  logic       ndp0;
  logic [7:0] an0;
  logic [2:0] dig0;

  logic [6:0] nhex1;
  logic       ndp1;
  logic [0:0] an1;
  logic [0:0] dig1;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  seg7_scan #(
    .NDIG(8), .SCAN_DIV(8),
    .BLANK_CYC(2), .AN_ACT_LOW(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .load(load),
    .data(data), .dp(dp), .blank(blank),
    .lz_en(lz_en), .nhex(nhex0), .ndp(ndp0),
    .an(an0), .dig_idx(dig0)
  );

  seg7_scan #(
    .NDIG(1), .SCAN_DIV(3),
    .BLANK_CYC(0), .AN_ACT_LOW(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .load(load),
    .data(data[3:0]), .dp(dp[0:0]),
    .blank(blank[0:0]), .lz_en(lz_en),
    .nhex(nhex1), .ndp(ndp1),
    .an(an1), .dig_idx(dig1)
  );

  typedef struct packed {
    logic [6:0]  nhex;
    logic        ndp;
    logic [15:0] an;
    logic [3:0]  dig;
  } exp_t;

  logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h58,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // t = edges since reset release; slot and
  // digit follow directly from it.
  function automatic exp_t model(
    input int nd, input int sd,
    input int bc, input bit al,
    input bit rst, input int t,
    input logic [63:0] d,
    input logic [15:0] p,
    input logic [15:0] b,
    input bit lz
  );
    exp_t e;
    int cnt;
    int dg;
    logic [15:0] off;
    logic [63:0] sh;
    off = al ? 16'((32'h1 << nd) - 1) : 16'h0;
    cnt = t % sd;
    dg = (t / sd) % nd;
    sh = d >> (4 * dg);
    e.nhex = 7'h7F;
    e.ndp = 1'b1;
    e.an = off;
    e.dig = 4'(dg);
    if (rst) begin
      e.dig = 4'h0;
      return e;
    end
    if (cnt < bc) return e;
    e.an = off ^ (16'h1 << dg);
    if (b[dg]) return e;
    if (lz && dg > 0 && sh == 64'h0) return e;
    e.nhex = SEG[sh[3:0]];
    e.ndp = ~p[dg];
    return e;
  endfunction

  logic        s_rst;
  logic        s_load;
  logic        s_lz;
  logic [31:0] s_data;
  logic [7:0]  s_dp;
  logic [7:0]  s_blank;

  always @(posedge clk) begin
    s_rst   <= rst_n;
    s_load  <= load;
    s_lz    <= lz_en;
    s_data  <= data;
    s_dp    <= dp;
    s_blank <= blank;
  end

  int          t = 0;
  logic [31:0] sh_d = '0;
  logic [7:0]  sh_p = '0;
  logic [7:0]  sh_b = '0;
  exp_t        e0;
  exp_t        e1;

  always @(negedge clk) begin
    if (!s_rst) begin
      t = 0;
      sh_d = '0;
      sh_p = '0;
      sh_b = '0;
    end else begin
      t++;
    end
    e0 = model(8, 8, 2, 1'b1, !s_rst, t,
      {32'h0, sh_d}, {8'h0, sh_p},
      {8'h0, sh_b}, s_lz);
    e1 = model(1, 3, 0, 1'b0, !s_rst, t,
      {60'h0, sh_d[3:0]}, {15'h0, sh_p[0]},
      {15'h0, sh_b[0]}, s_lz);
    if (s_rst && s_load) begin
      sh_d = s_data;
      sh_p = s_dp;
      sh_b = s_blank;
    end
    vecs++;
    if (nhex0 !== e0.nhex || ndp0 !== e0.ndp ||
        an0 !== e0.an[7:0] ||
        dig0 !== e0.dig[2:0]) begin
      errs++;
      $display(
        "FAIL scan8 t=%0d got nhex=%h ndp=%b an=%h dig=%0d required nhex=%h ndp=%b an=%h dig=%0d",
        t, nhex0, ndp0, an0, dig0,
        e0.nhex, e0.ndp, e0.an[7:0], e0.dig);
    end
    vecs++;
    if (nhex1 !== e1.nhex || ndp1 !== e1.ndp ||
        an1 !== e1.an[0:0] ||
        dig1 !== e1.dig[0:0]) begin
      errs++;
      $display(
        "FAIL scan1 t=%0d got nhex=%h ndp=%b an=%b dig=%0d required nhex=%h ndp=%b an=%b dig=%0d",
        t, nhex1, ndp1, an1, dig1,
        e1.nhex, e1.ndp, e1.an[0], e1.dig);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(
    input string nm,
    input logic [7:0] got,
    input logic [7:0] req
  );
    vecs++;
    if (got !== req) begin
      errs++;
      $display("FAIL %s got %h required %h",
        nm, got, req);
    end
  endtask

  task automatic wait_slot(
    input int d,
    input logic [7:0] a
  );
    int n;
    n = 0;
    while (!(dig0 == 3'(d) && an0 == a) &&
           n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      vecs++;
      errs++;
      $display(
        "FAIL wait_slot got timeout required dig=%0d an=%h",
        d, a);
    end
  endtask

  task automatic do_load(
    input logic [31:0] d,
    input logic [7:0] p,
    input logic [7:0] b
  );
    data = d;
    dp = p;
    blank = b;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    load  = 1'b1;
    lz_en = 1'b0;
    data  = 32'hFFFF_FFFF;
    dp    = 8'hFF;
    blank = 8'h00;
    repeat (3) step();
    chk("rst_nhex", {1'b0, nhex0}, 8'h7F);
    chk("rst_ndp", {7'h0, ndp0}, 8'h01);
    chk("rst_an", an0, 8'hFF);
    chk("rst_dig", {5'h0, dig0}, 8'h00);

    rst_n = 1'b1;
    do_load(32'hFEDC_BA98, 8'h00, 8'h00);
    repeat (70) step();
    wait_slot(7, 8'h7F);
    chk("dec_d7", {1'b0, nhex0}, 8'h0E);
    wait_slot(0, 8'hFE);
    chk("dec_d0", {1'b0, nhex0}, 8'h00);
    wait_slot(1, 8'hFD);
    chk("dec_d1", {1'b0, nhex0}, 8'h10);

    lz_en = 1'b1;
    do_load(32'h0000_0450, 8'h10, 8'h00);
    wait_slot(2, 8'hFB);
    chk("lz_d2", {1'b0, nhex0}, 8'h19);
    wait_slot(1, 8'hFD);
    chk("lz_d1", {1'b0, nhex0}, 8'h12);
    wait_slot(4, 8'hEF);
    chk("lz_d4_dp", {7'h0, ndp0}, 8'h01);
    wait_slot(5, 8'hDF);
    chk("lz_d5", {1'b0, nhex0}, 8'h7F);
    wait_slot(0, 8'hFE);
    chk("lz_d0", {1'b0, nhex0}, 8'h40);
    do_load(32'h0, 8'h00, 8'h00);
    wait_slot(3, 8'hF7);
    chk("lz0_d3", {1'b0, nhex0}, 8'h7F);
    wait_slot(0, 8'hFE);
    chk("lz0_d0", {1'b0, nhex0}, 8'h40);

    lz_en = 1'b0;
    do_load(32'h1234_5678, 8'h05, 8'h02);
    wait_slot(1, 8'hFD);
    chk("blk_d1_hex", {1'b0, nhex0}, 8'h7F);
    chk("blk_d1_dp", {7'h0, ndp0}, 8'h01);
    wait_slot(2, 8'hFB);
    chk("dp_d2", {7'h0, ndp0}, 8'h00);
    chk("dp_d2_hex", {1'b0, nhex0}, 8'h02);
    wait_slot(3, 8'hF7);
    chk("dp_d3", {7'h0, ndp0}, 8'h01);
    wait_slot(0, 8'hFE);
    chk("dp_d0", {7'h0, ndp0}, 8'h00);

    wait_slot(3, 8'hF7);
    step();
    do_load(32'h8765_4321, 8'h00, 8'h00);
    repeat (20) step();

    for (int n = 0; n < 16 && (t % 8) != 7; n++)
      step();
    do_load(32'hAAAA_5555, 8'hF0, 8'h00);
    repeat (70) step();

    wait_slot(5, 8'hDF);
    rst_n = 1'b0;
    step();
    chk("mid_rst_dig", {5'h0, dig0}, 8'h00);
    chk("mid_rst_an", an0, 8'hFF);
    rst_n = 1'b1;
    step();
    chk("rel_blank_an", an0, 8'hFF);
    step();
    chk("rel_d0_an", an0, 8'hFE);
    chk("rel_d0_hex", {1'b0, nhex0}, 8'h40);
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==",
      vecs, errs);
    $finish;
  end

endmodule
